// File: rtl/spi_pkg.sv
// Shared types and limits for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int MIN_DATA_W = 2;
  localparam int MIN_NUM_CS = 1;

  // A single peripheral still gets a 1-bit select port.
  function automatic int sel_w(input int n);
    return (n > MIN_NUM_CS) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider and edge generator: one tick every clk_div+1 cycles while run is high;
// sck toggles on each tick while edge_en is high and otherwise rests at cpol.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             edge_en,
  input  logic             cpol,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick,
  output logic             lead_pulse,
  output logic             trail_pulse,
  output logic             sck
);

  logic [DIV_W-1:0] cnt;
  logic             phase;

  // Compare-then-reload keeps clk_div = all ones free of wrap artefacts.
  assign tick        = run && (cnt == clk_div);
  assign lead_pulse  = tick && edge_en && !phase;
  assign trail_pulse = tick && edge_en && phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      sck   <= 1'b0;
    end else begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + 1'b1;

      if (!edge_en) begin
        phase <= 1'b0;
        sck   <= cpol;
      end else if (tick) begin
        phase <= ~phase;
        sck   <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Multi-mode SPI master: DATA_W-bit MSB-first transfers to one of NUM_CS peripherals.
// Start is taken only in IDLE (not in the done cycle); done pulses at 1+(2*DATA_W+1)*H.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [sel_w(NUM_CS)-1:0]  cs_sel,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      miso,
  output logic                      sck,
  output logic                      mosi,
  output logic [NUM_CS-1:0]         cs_n,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         rx_data
);

  localparam int CNT_W = $clog2(2*DATA_W+1);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W-1);

  spi_state_t       state, state_nxt;
  spi_mode_t        mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [CNT_W-1:0] edge_cnt;
  logic accept, run, edge_en, tick, lead_pulse, trail_pulse;
  logic edge_pulse, shift_ev, sample_ev, last_edge;

  assign accept     = (state == ST_IDLE) && start && !done && (32'(cs_sel) < NUM_CS);
  assign run        = (state != ST_IDLE);
  assign edge_en    = (state == ST_LEAD) || (state == ST_SHIFT);
  assign edge_pulse = lead_pulse || trail_pulse;
  assign shift_ev   = mode_q.cpha ? lead_pulse : trail_pulse;
  assign sample_ev  = mode_q.cpha ? trail_pulse : lead_pulse;
  assign last_edge  = edge_pulse && (edge_cnt == LAST_EDGE);
  assign busy       = run;

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .edge_en     (edge_en),
    .cpol        (mode_q.cpol),
    .clk_div     (div_q),
    .tick        (tick),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse),
    .sck         (sck)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)     state_nxt = ST_LEAD;
      ST_LEAD:  if (lead_pulse) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_edge)  state_nxt = ST_TRAIL;
      ST_TRAIL: if (tick)       state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= '0;
      div_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      edge_cnt <= '0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= 1'b0;

      // Mode tracks the pins while idle so sck rests at the requested polarity.
      if (state == ST_IDLE) begin
        mode_q.cpol <= cpol;
        mode_q.cpha <= cpha;
      end

      if (accept) begin
        div_q    <= clk_div;
        cs_n     <= ~(NUM_CS'(1) << cs_sel);
        edge_cnt <= '0;
        rx_q     <= '0;
        if (cpha) begin
          tx_q <= tx_data;
          mosi <= 1'b0;
        end else begin
          tx_q <= tx_data << 1;
          mosi <= tx_data[DATA_W-1];
        end
      end

      if (edge_pulse) edge_cnt <= edge_cnt + 1'b1;

      if (shift_ev) begin
        mosi <= tx_q[DATA_W-1];
        tx_q <= tx_q << 1;
      end

      if (sample_ev) rx_q <= {rx_q[DATA_W-2:0], miso};

      if ((state == ST_TRAIL) && tick) begin
        cs_n    <= '1;
        done    <= 1'b1;
        rx_data <= rx_q;
        mosi    <= 1'b0;
      end
    end
  end

endmodule
